// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage multiply/divide sequencer.
//   MULT/MULTU complete in the issue cycle. MADD*/MSUB* latch the product and
//   write HI/LO one cycle later. DIV/DIVU drive the external multi-cycle
//   divider and request a pipeline stall until the result comes back.
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   op_i               operation code (1 MULT .. 8 MSUBU, others none)
//   reg1_i, reg2_i     rs/rt operands
//   hi_i, lo_i         current HI/LO
//   stall_i, flush_i   downstream stall, pipeline flush
//   div_*_o            divider start/annul/signed/operands
//   div_result_i       {remainder, quotient}; div_ready_i result valid
//   stallreq_o         stall request
//   hilo_we_o, hi_o, lo_o  HI/LO write port
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMadd  = 4'd5;
  localparam logic [3:0] OpMaddu = 4'd6;
  localparam logic [3:0] OpMsub  = 4'd7;
  localparam logic [3:0] OpMsubu = 4'd8;

  typedef enum logic [2:0] {StIdle, StMacc, StDivIssue, StDivWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic        signed_q, signed_d;
  logic [63:0] prod_q, prod_d;
  logic        acc_sub_q, acc_sub_d;
  logic [63:0] res_q, res_d;

  logic        mul_signed;
  logic [63:0] a_ext, b_ext, product, macc_sum;
  logic        start_c, annul_c, stallreq_c, we_c;
  logic [63:0] hilo_c;

  // Sign/zero extension to 64 bits makes the truncated 64-bit product correct
  // for both signed and unsigned operands.
  assign mul_signed = (op_i == OpMult) || (op_i == OpMadd) || (op_i == OpMsub);
  assign a_ext      = mul_signed ? {{32{reg1_i[31]}}, reg1_i} : {32'b0, reg1_i};
  assign b_ext      = mul_signed ? {{32{reg2_i[31]}}, reg2_i} : {32'b0, reg2_i};
  assign product    = a_ext * b_ext;
  assign macc_sum   = acc_sub_q ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    signed_d   = signed_q;
    prod_d     = prod_q;
    acc_sub_d  = acc_sub_q;
    res_d      = res_q;
    start_c    = 1'b0;
    annul_c    = 1'b0;
    stallreq_c = 1'b0;
    we_c       = 1'b0;
    hilo_c     = 64'b0;

    unique case (state_q)
      StIdle: begin
        unique case (op_i)
          OpMult, OpMultu: begin
            hilo_c = product;
            we_c   = 1'b1;
            if (stall_i) begin
              res_d   = product;
              state_d = StDone;
            end
          end
          OpMadd, OpMaddu, OpMsub, OpMsubu: begin
            prod_d     = product;
            acc_sub_d  = (op_i == OpMsub) || (op_i == OpMsubu);
            stallreq_c = 1'b1;
            state_d    = StMacc;
          end
          OpDiv, OpDivu: begin
            op1_d      = reg1_i;
            op2_d      = reg2_i;
            signed_d   = (op_i == OpDiv);
            stallreq_c = 1'b1;
            state_d    = StDivIssue;
          end
          default: ;
        endcase
      end
      StMacc: begin
        hilo_c  = macc_sum;
        we_c    = 1'b1;
        if (stall_i) begin
          res_d   = macc_sum;
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDivIssue: begin
        // Ready is ignored here so a stale result from a previous divide
        // cannot be taken for this one.
        start_c    = 1'b1;
        stallreq_c = 1'b1;
        state_d    = StDivWait;
      end
      StDivWait: begin
        start_c = 1'b1;
        if (div_ready_i) begin
          hilo_c  = div_result_i;
          we_c    = 1'b1;
          res_d   = div_result_i;
          state_d = stall_i ? StDone : StIdle;
        end else begin
          stallreq_c = 1'b1;
        end
      end
      StDone: begin
        hilo_c = res_q;
        we_c   = 1'b1;
        if (!stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d    = StIdle;
      op1_d      = op1_q;
      op2_d      = op2_q;
      signed_d   = signed_q;
      prod_d     = prod_q;
      acc_sub_d  = acc_sub_q;
      res_d      = res_q;
      start_c    = 1'b0;
      stallreq_c = 1'b0;
      we_c       = 1'b0;
      annul_c    = (state_q == StDivIssue) || (state_q == StDivWait);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op1_q     <= '0;
      op2_q     <= '0;
      signed_q  <= 1'b0;
      prod_q    <= '0;
      acc_sub_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      signed_q  <= signed_d;
      prod_q    <= prod_d;
      acc_sub_q <= acc_sub_d;
      res_q     <= res_d;
    end
  end

  // Outputs are combinational; gating with rst keeps them at 0 while reset is
  // held even though op_i may be presenting a live operation.
  assign div_start_o   = rst & start_c;
  assign div_annul_o   = rst & annul_c;
  assign stallreq_o    = rst & stallreq_c;
  assign hilo_we_o     = rst & we_c;
  assign hi_o          = rst ? hilo_c[63:32] : 32'b0;
  assign lo_o          = rst ? hilo_c[31:0] : 32'b0;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  logic        clk, rst;
  logic [3:0]  op;
  logic [31:0] reg1, reg2, hi_in, lo_in;
  logic        stall, flush;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq, hilo_we;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;
  int div_lat = 3;
  int div_cnt = 0;

  ex_muldiv_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op_i          (op),
    .reg1_i        (reg1),
    .reg2_i        (reg2),
    .hi_i          (hi_in),
    .lo_i          (lo_in),
    .stall_i       (stall),
    .flush_i       (flush),
    .div_start_o   (div_start),
    .div_annul_o   (div_annul),
    .div_signed_o  (div_signed),
    .div_opdata1_o (div_opdata1),
    .div_opdata2_o (div_opdata2),
    .div_result_i  (div_result),
    .div_ready_i   (div_ready),
    .stallreq_o    (stallreq),
    .hilo_we_o     (hilo_we),
    .hi_o          (hi_out),
    .lo_o          (lo_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sq, sr;
    logic [31:0] uq, ur;
    if (b == 0) return 64'b0;
    if (s) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      return {sr[31:0], sq[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     acc = {h, l};
    logic [63:0]     sp, up;
    sp = sa * sb;
    up = ua * ub;
    case (o)
      4'd1: return sp;
      4'd2: return up;
      4'd3: return div_ref(a, b, 1'b1);
      4'd4: return div_ref(a, b, 1'b0);
      4'd5: return acc + sp;
      4'd6: return acc + up;
      4'd7: return acc - sp;
      4'd8: return acc - up;
      default: return 64'b0;
    endcase
  endfunction

  // Divider stand-in: result appears div_lat+1 edges after start rises, read
  // from the operand outputs at that final step; dropping start frees it.
  always @(posedge clk) begin
    if (!rst || !div_start) begin
      div_cnt   <= 0;
      div_ready <= 1'b0;
    end else if (!div_ready) begin
      if (div_cnt == div_lat) begin
        div_ready  <= 1'b1;
        div_result <= div_ref(div_opdata1, div_opdata2, div_signed);
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an op and step until the HI/LO write; stall cycles counted on the way.
  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] exp, input int exp_stalls);
    logic [63:0] got;
    int          stalls;
    bit          done;
    op = o; reg1 = r1; reg2 = r2; hi_in = h; lo_in = l;
    stalls = 0; done = 0; got = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (hilo_we) begin
        got  = {hi_out, lo_out};
        done = 1;
      end else begin
        if (stallreq) stalls++;
        if (i >= 1 && (o == 4'd3 || o == 4'd4))
          chk({name, " div operands"}, {div_opdata1, div_opdata2}, {r1, r2});
      end
      @(posedge clk);
      #1;
    end
    chk({name, " completed"}, {63'b0, done}, 64'd1);
    chk({name, " result"}, got, exp);
    chk({name, " stall cycles"}, stalls, exp_stalls);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r1, r2, h, l;
    logic        we, st;
    logic [63:0] hl;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b, h, l;

    rst = 0; op = 4'd1; reg1 = 5; reg2 = 3; hi_in = 0; lo_in = 0;
    stall = 0; flush = 0;
    #3;
    chk("reset outputs", {31'b0, stallreq, hilo_we, hi_out, lo_out, div_start, div_annul,
                          div_signed, div_opdata1, div_opdata2}, 0);
    op = 0;
    tick(); tick();
    rst = 1;
    tick();

    // First-cycle behaviour from IDLE
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFA};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3, 0, 0, 1'b1, 1'b0, 64'h00000002_FFFFFFFA};
    vecs[2] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 1'b1, 1'b0, 64'h3FFFFFFF_00000001};
    vecs[3] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[4] = '{4'd1, 32'h80000000, 32'h80000000, 0, 0, 1'b1, 1'b0, 64'h40000000_00000000};
    vecs[5] = '{4'd5, 32'd3, 32'd4, 0, 0, 1'b0, 1'b1, 64'd0};
    vecs[6] = '{4'd3, 32'd9, 32'd2, 0, 0, 1'b0, 1'b1, 64'd0};
    vecs[7] = '{4'd9, 32'd9, 32'd2, 0, 0, 1'b0, 1'b0, 64'd0};
    vecs[8] = '{4'd15, 32'd9, 32'd2, 0, 0, 1'b0, 1'b0, 64'd0};
    for (int i = 0; i < 9; i++) begin
      op = vecs[i].op; reg1 = vecs[i].r1; reg2 = vecs[i].r2;
      hi_in = vecs[i].h; lo_in = vecs[i].l;
      #1;
      chk($sformatf("vec%0d we/stall", i), {62'b0, hilo_we, stallreq},
          {62'b0, vecs[i].we, vecs[i].st});
      chk($sformatf("vec%0d hilo", i), {hi_out, lo_out}, vecs[i].hl);
      tick();
      op = 0; flush = 1;
      tick();
      flush = 0;
    end

    // MADDU / MSUBU
    do_op("maddu", 4'd6, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 64'h00000001_00000000, 1);
    do_op("msubu", 4'd8, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 1);
    op = 0; tick();

    // DIV -7/2, then start must drop the next cycle
    div_lat = 5;
    do_op("div -7/2", 4'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 7);
    op = 0;
    #1;
    chk("div start dropped", {63'b0, div_start}, 0);
    tick();

    // Divide by zero, then immediate second DIVU
    div_lat = 2;
    do_op("divu 5/0", 4'd4, 32'd5, 32'd0, 0, 0, 64'd0, 4);
    do_op("divu 9/4", 4'd4, 32'd9, 32'd4, 0, 0, {32'd1, 32'd2}, 4);
    op = 0; tick();

    // Flush in the 10th DIV_WAIT cycle
    div_lat = 30;
    op = 4'd3; reg1 = 100; reg2 = 7;
    for (int k = 0; k < 11; k++) tick();
    #1;
    chk("pre-flush stallreq", {63'b0, stallreq}, 1);
    flush = 1;
    #1;
    chk("flush annul/stall/we/start", {60'b0, div_annul, stallreq, hilo_we, div_start},
        {60'b0, 4'b1000});
    tick();
    flush = 0; op = 0;
    #1;
    chk("post-flush idle", {61'b0, stallreq, hilo_we, div_start}, 0);
    tick();
    div_lat = 4;
    do_op("div after flush", 4'd3, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14}, 6);
    op = 0; tick();

    // MADD held by downstream stall
    op = 4'd5; reg1 = 3; reg2 = 4; hi_in = 0; lo_in = 10;
    #1;
    chk("madd hold issue stall", {63'b0, stallreq}, 1);
    tick();
    stall = 1;
    #1;
    chk("madd hold macc", {31'b0, hilo_we, hi_out, lo_out}, {31'b0, 1'b1, 64'd22});
    for (int k = 0; k < 2; k++) begin
      tick();
      lo_in = 999 + k;
      #1;
      chk("madd hold done", {30'b0, stallreq, hilo_we, hi_out, lo_out},
          {30'b0, 2'b01, 64'd22});
    end
    tick();
    stall = 0;
    #1;
    chk("madd hold release", {31'b0, hilo_we, hi_out, lo_out}, {31'b0, 1'b1, 64'd22});
    tick();
    op = 0;
    #1;
    chk("madd hold back to idle", {62'b0, hilo_we, stallreq}, 0);
    tick();

    // Reset mid DIV_WAIT
    div_lat = 30;
    op = 4'd3; reg1 = 50; reg2 = 3;
    for (int k = 0; k < 4; k++) tick();
    rst = 0;
    #1;
    chk("mid-div reset outputs", {31'b0, stallreq, hilo_we, hi_out, lo_out, div_start,
                                  div_annul, div_signed, div_opdata1, div_opdata2}, 0);
    op = 0;
    tick();
    rst = 1;
    tick();
    #1;
    chk("after reset idle", {61'b0, stallreq, hilo_we, div_start}, 0);
    do_op("mult after reset", 4'd1, 32'd6, 32'd7, 0, 0, 64'd42, 0);
    op = 0; tick();

    // Randomized ops against the arithmetic reference model
    for (int n = 0; n < 120; n++) begin
      o = 4'($urandom_range(1, 8));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      h = $urandom;
      l = $urandom;
      div_lat = $urandom_range(1, 6);
      do_op($sformatf("rand%0d op%0d", n, o), o, a, b, h, l, ref_model(o, a, b, h, l),
            (o == 4'd1 || o == 4'd2) ? 0 : (o == 4'd3 || o == 4'd4) ? div_lat + 2 : 1);
      if ($urandom_range(0, 1) == 0) begin
        op = 0;
        tick();
      end
    end
    op = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

EX-stage multiply/divide sequencer feeding the multi-cycle divider and producing the HI/LO write for the EX/MEM register. It executes MULT/MULTU in one cycle and MADD/MADDU/MSUB/MSUBU in two. For DIV/DIVU it latches operands, drives the divider's start/annul/signed/operand inputs and holds a pipeline stall request until the quotient and remainder come back.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- op_i  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU; other codes = none.
- reg1_i, reg2_i  in  32  rs and rt operands (already forwarded).
- hi_i, lo_i  in  32  current HI/LO (already forwarded).
- stall_i  in  1  downstream stall; EX/MEM does not capture this cycle.
- flush_i  in  1  pipeline flush; kills the op in EX.
- div_start_o, div_annul_o, div_signed_o  out  1  to the divider's start_i, annul_i and signed_div_i.
- div_opdata1_o, div_opdata2_o  out  32  to the divider's operand inputs (dividend, divisor).
- div_result_i  in  64  from the divider: [63:32] remainder, [31:0] quotient.
- div_ready_i  in  1  divider result valid.
- stallreq_o  out  1  stall request to pipeline control.
- hilo_we_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32  HI/LO write data.

## Operation
- States: IDLE, MACC, DIV_ISSUE, DIV_WAIT, DONE.
- Internal registers:
  - op1_q, op2_q (32 each), signed_q: divider operands and signedness.
  - prod_q (64): latched product.
  - acc_sub_q: accumulate direction, 1 = subtract.
  - res_q (64): held result.
- IDLE:
  - MULT/MULTU: product = signed/unsigned 64-bit reg1_i*reg2_i. Drive {hi_o,lo_o} = product and hilo_we_o=1 combinationally; no stall.
    - If stall_i=1: latch the product into res_q and go to DONE.
  - MADD*/MSUB*: latch the product into prod_q and the direction into acc_sub_q. stallreq_o=1, hilo_we_o=0, go to MACC.
  - DIV/DIVU: latch op1_q=reg1_i, op2_q=reg2_i, signed_q=(op_i==DIV). stallreq_o=1, go to DIV_ISSUE.
- MACC:
  - {hi_o,lo_o} = {hi_i,lo_i} ± prod_q, taken modulo 2^64. hilo_we_o=1, stallreq_o=0.
  - If stall_i=1: latch the sum into res_q and go to DONE; otherwise go to IDLE.
- DIV_ISSUE: div_start_o=1, stallreq_o=1. div_ready_i is ignored in this state. Go to DIV_WAIT.
- DIV_WAIT:
  - div_start_o=1, stallreq_o=1 until div_ready_i=1.
  - On the cycle div_ready_i=1:
    - hi_o = div_result_i[63:32], lo_o = div_result_i[31:0], hilo_we_o=1, stallreq_o=0.
    - Latch the result into res_q.
    - Go to DONE if stall_i=1, else go to IDLE.
- DONE: hi_o/lo_o = res_q, hilo_we_o=1, stallreq_o=0, div_start_o=0. Return to IDLE when stall_i=0.
  - No re-issue or re-accumulation while held, even though op_i is unchanged.
- Divider operands come from op1_q/op2_q, which stay constant from DIV_ISSUE to completion. The divider reads them at its final sign-fix step.
- div_signed_o = signed_q.
- div_start_o=0 in IDLE, MACC and DONE. Dropping start returns the divider to its free state.
- Divide by zero: the divider returns 0; the block passes through hi=lo=0 without special handling.
- Flush: flush_i=1 in any state forces the following:
  - Next state is IDLE.
  - hilo_we_o=0, stallreq_o=0 and div_start_o=0 this cycle.
  - div_annul_o=1 this cycle if state is DIV_ISSUE or DIV_WAIT; div_annul_o=0 in all other cases.
  - Flush overrides a simultaneous div_ready_i or a new op.
- Reset: state=IDLE; all internal registers 0. All outputs read 0, i.e. stallreq_o, hilo_we_o, hi_o, lo_o, div_start_o, div_annul_o, div_signed_o, div_opdata1_o and div_opdata2_o.

## Timing
- MULT*: result in the issue cycle; 0 stall cycles.
- MADD*/MSUB*: 1 stall cycle; the write happens in the MACC cycle.
- DIV*: stallreq_o is high from the issue cycle through the last cycle before div_ready_i is seen. The write happens in the div_ready_i cycle. Latency equals the divider latency plus the IDLE and DIV_ISSUE cycles; the block never assumes a fixed count.
- A back-to-back DIV issued right after completion passes through DIV_ISSUE, so a stale ready from the divider's end state is never taken as the new result.
- All outputs are combinational from state, registers and inputs. There is no output register stage.

## Test plan
- MULT reg1=0xFFFFFFFE, reg2=3 -> same cycle hilo_we=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA, stallreq=0. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MADDU hi=0, lo=0xFFFFFFFF, reg1=reg2=1 -> cycle 1: stallreq=1, we=0; cycle 2: we=1, hi=1, lo=0. MSUBU hi=lo=0, 1*1 -> hi=lo=0xFFFFFFFF.
- DIV with divider model, reg1=0xFFFFFFF9 (-7), reg2=2:
  - stallreq high throughout; divider operands stable.
  - On ready: hi=0xFFFFFFFF, lo=0xFFFFFFFD.
  - div_start low the next cycle.
- DIVU 5/0 -> completes with hi=0, lo=0, we=1. An immediate second DIVU 9/4 -> hi=1, lo=2.
- Flush in the 10th DIV_WAIT cycle -> div_annul=1 that cycle, stallreq=0, we=0, state IDLE. A DIV issued 2 cycles later completes correctly.
- MADD completes with stall_i held high 3 cycles -> hi/lo constant and equal to a single accumulation. rst pulled low mid-DIV_WAIT -> all outputs 0 immediately; after release the block is IDLE.
